// File: rtl/credit_vc_send_port_if.sv
// Bridge-to-router send port bundle: flit offer, router flit strobe, credit return.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

interface credit_vc_send_port_if #(
    parameter int FLIT_WIDTH = `FLIT_WIDTH,
    parameter int VC_BITS    = `VC_BITS
);
    logic [FLIT_WIDTH-1:0] put_flit;
    logic [VC_BITS-1:0]    put_flit_vc;
    logic                  put_flit_valid;
    logic                  put_flit_ready;
    logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in;
    logic                  EN_send_ports_putFlit;
    logic [VC_BITS:0]      send_ports_getCredits;
    logic                  EN_send_ports_getCredits;
    logic                  credit_overflow;

    modport master (
        output put_flit, put_flit_vc, put_flit_valid, send_ports_getCredits,
        input  put_flit_ready, send_ports_putFlit_flit_in, EN_send_ports_putFlit,
               EN_send_ports_getCredits, credit_overflow
    );

    modport slave (
        input  put_flit, put_flit_vc, put_flit_valid, send_ports_getCredits,
        output put_flit_ready, send_ports_putFlit_flit_in, EN_send_ports_putFlit,
               EN_send_ports_getCredits, credit_overflow
    );
endinterface

// File: rtl/credit_vc_send_port.sv
// Per-VC flit buffers with credit tracking and round-robin send to one router port; flits leave at earliest one cycle after acceptance.
// Backpressure: put_flit_ready drops when the addressed VC buffer is full or the VC id is out of range; a VC without credits simply holds.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

module credit_vc_send_port #(
    parameter int FLIT_WIDTH = `FLIT_WIDTH,
    parameter int NUM_VCS    = 2,
    parameter int VC_BITS    = `VC_BITS,
    parameter int VC_LSB     = 0,
    parameter int BUF_DEPTH  = 4,
    parameter int CREDITS    = 8
) (
    input logic                  CLK,
    input logic                  RST_N,
    credit_vc_send_port_if.slave bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam logic [CRD_W-1:0]   CRD_MAX   = CRD_W'(CREDITS);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(BUF_DEPTH);
    localparam logic [VC_BITS-1:0] LAST_INIT = VC_BITS'(NUM_VCS - 1);

    logic [FLIT_WIDTH-1:0] mem [NUM_VCS][BUF_DEPTH];
    logic [PTR_W-1:0]      wrPtr  [NUM_VCS];
    logic [PTR_W-1:0]      rdPtr  [NUM_VCS];
    logic [CNT_W-1:0]      count  [NUM_VCS];
    logic [CRD_W-1:0]      credit [NUM_VCS];
    logic [VC_BITS-1:0]    last;
    logic                  overflowFlag;

    logic [NUM_VCS-1:0]    pushVec, popVec, retVec, satVec, eligVec;
    logic                  putFull, putAccept, retVld, retBad, grantVld;
    logic [VC_BITS-1:0]    grantVc, retId;
    logic [FLIT_WIDTH-1:0] headFlit, sendFlit;

    assign retVld = bus.send_ports_getCredits[VC_BITS];
    assign retId  = bus.send_ports_getCredits[VC_BITS-1:0];
    assign retBad = retVld && (int'(retId) >= NUM_VCS);

    // An out-of-range VC id finds no buffer and therefore reads as full.
    always_comb begin
        putFull = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (int'(bus.put_flit_vc) == v) putFull = (count[v] == CNT_FULL);
        end
    end

    assign putAccept = RST_N && bus.put_flit_valid && !putFull;

    always_comb begin
        eligVec = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            eligVec[v] = (count[v] != '0) && (credit[v] != '0);
        end
    end

    // Scan from farthest to nearest so the VC closest after `last` wins.
    always_comb begin
        grantVld = 1'b0;
        grantVc  = '0;
        for (int off = NUM_VCS; off >= 1; off--) begin
            if (eligVec[(int'(last) + off) % NUM_VCS]) begin
                grantVld = RST_N;
                grantVc  = VC_BITS'((int'(last) + off) % NUM_VCS);
            end
        end
    end

    always_comb begin
        pushVec = '0;
        popVec  = '0;
        retVec  = '0;
        satVec  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            pushVec[v] = putAccept && (int'(bus.put_flit_vc) == v);
            popVec[v]  = grantVld && (int'(grantVc) == v);
            retVec[v]  = retVld && (int'(retId) == v);
            satVec[v]  = retVec[v] && !popVec[v] && (credit[v] == CRD_MAX);
        end
    end

    always_comb begin
        headFlit = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (popVec[v]) headFlit = mem[v][rdPtr[v]];
        end
        sendFlit = '0;
        if (grantVld) begin
            sendFlit                    = headFlit;
            sendFlit[FLIT_WIDTH-1]      = 1'b1;
            sendFlit[VC_LSB +: VC_BITS] = grantVc;
        end
    end

    assign bus.put_flit_ready             = RST_N && !putFull;
    assign bus.send_ports_putFlit_flit_in = sendFlit;
    assign bus.EN_send_ports_putFlit      = grantVld;
    assign bus.EN_send_ports_getCredits   = RST_N;
    assign bus.credit_overflow            = RST_N && overflowFlag;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wrPtr[v]  <= '0;
                rdPtr[v]  <= '0;
                count[v]  <= '0;
                credit[v] <= CRD_MAX;
            end
            last         <= LAST_INIT;
            overflowFlag <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (pushVec[v]) wrPtr[v] <= wrPtr[v] + 1'b1;
                if (popVec[v])  rdPtr[v] <= rdPtr[v] + 1'b1;
                if (pushVec[v] && !popVec[v])      count[v] <= count[v] + 1'b1;
                else if (!pushVec[v] && popVec[v]) count[v] <= count[v] - 1'b1;
                // A send and a return on the same VC cancel out.
                if (popVec[v] && !retVec[v])                     credit[v] <= credit[v] - 1'b1;
                else if (retVec[v] && !popVec[v] && !satVec[v])  credit[v] <= credit[v] + 1'b1;
            end
            if (grantVld) last <= grantVc;
            if (retBad || (|satVec)) overflowFlag <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if (pushVec[v]) mem[v][wrPtr[v]] <= bus.put_flit;
        end
    end
endmodule

// File: tb/tb_credit_vc_send_port.sv
// Randomized and directed bench for credit_vc_send_port against a queue-based reference model.
module tb_credit_vc_send_port;
    localparam int FW   = 32;
    localparam int NV   = 3;
    localparam int VB   = 2;
    localparam int VLSB = 4;
    localparam int BD   = 4;
    localparam int CR   = 8;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    credit_vc_send_port_if #(.FLIT_WIDTH(FW), .VC_BITS(VB)) vif();

    credit_vc_send_port #(
        .FLIT_WIDTH(FW), .NUM_VCS(NV), .VC_BITS(VB), .VC_LSB(VLSB),
        .BUF_DEPTH(BD), .CREDITS(CR)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(vif)
    );

    int vecs = 0;
    int errs = 0;

    logic [FW-1:0] mq [NV][$];
    int            mCred [NV];
    int            mLast;
    bit            mOvf;

    logic          obsEn, obsRdy, obsOvf;
    logic [FW-1:0] obsFlit;
    int            obsVc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VB:0] crdOf(input int id);
        return {1'b1, id[VB-1:0]};
    endfunction

    // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic step(input bit rst, input bit vld, input int vc, input logic [FW-1:0] f,
                        input logic [VB:0] crd);
        bit            rdy, gv;
        int            g, id;
        logic [FW-1:0] ef;
        @(negedge CLK);
        RST_N                     = rst;
        vif.put_flit_valid        = vld;
        vif.put_flit_vc           = vc[VB-1:0];
        vif.put_flit              = f;
        vif.send_ports_getCredits = crd;

        rdy = 1'b0;
        if (rst && vc < NV) rdy = (mq[vc].size() < BD);
        gv = 1'b0;
        g  = 0;
        if (rst) begin
            for (int off = 1; off <= NV; off++) begin
                int i;
                i = (mLast + off) % NV;
                if (!gv && mq[i].size() > 0 && mCred[i] > 0) begin
                    gv = 1'b1;
                    g  = i;
                end
            end
        end
        ef = '0;
        if (gv) begin
            ef = mq[g][0];
            ef[FW-1] = 1'b1;
            ef[VLSB +: VB] = g[VB-1:0];
        end

        #1;
        obsEn   = vif.EN_send_ports_putFlit;
        obsFlit = vif.send_ports_putFlit_flit_in;
        obsVc   = int'(obsFlit[VLSB +: VB]);
        obsRdy  = vif.put_flit_ready;
        obsOvf  = vif.credit_overflow;
        chk("ready", obsRdy, rdy);
        chk("send_en", obsEn, gv);
        chk("send_flit", obsFlit, ef);
        chk("credit_en", vif.EN_send_ports_getCredits, rst);
        chk("overflow", obsOvf, rst && mOvf);

        @(posedge CLK);
        if (!rst) begin
            for (int v = 0; v < NV; v++) begin
                mq[v].delete();
                mCred[v] = CR;
            end
            mLast = NV - 1;
            mOvf  = 1'b0;
        end else begin
            id = int'(crd[VB-1:0]);
            if (gv) begin
                void'(mq[g].pop_front());
                mLast = g;
            end
            if (vld && rdy) mq[vc].push_back(f);
            if (crd[VB]) begin
                if (id >= NV) mOvf = 1'b1;
                else if (gv && g == id) mOvf = mOvf;
                else if (mCred[id] == CR) mOvf = 1'b1;
                else mCred[id]++;
            end
            if (gv && !(crd[VB] && id == g)) mCred[g]--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0);
    endtask

    task automatic doReset;
        step(0, 0, 0, '0, '0);
    endtask

    initial begin
        int cnt, prevVc, id;
        logic [VB:0] crd;
        vif.put_flit = '0;
        vif.put_flit_vc = '0;
        vif.put_flit_valid = 1'b0;
        vif.send_ports_getCredits = '0;
        for (int v = 0; v < NV; v++) mCred[v] = CR;
        mLast = NV - 1;
        mOvf = 1'b0;

        // Reset values
        for (int i = 0; i < 3; i++) begin
            doReset();
            chk("rst_ready", obsRdy, 0);
            chk("rst_en", obsEn, 0);
        end
        step(1, 0, 0, '0, '0);
        chk("idle_rdy_vc0", obsRdy, 1);
        chk("idle_ovf", obsOvf, 0);
        step(1, 0, 1, '0, '0);
        chk("idle_rdy_vc1", obsRdy, 1);

        // Single flit on vc1
        step(1, 1, 1, 32'h0000_00AB, '0);
        chk("single_t_en", obsEn, 0);
        idle(1);
        chk("single_t1_en", obsEn, 1);
        chk("single_flit", obsFlit, 32'h8000_009B);
        idle(1);
        chk("single_t2_en", obsEn, 0);

        // Credit exhaustion, then backpressure on a full vc0
        doReset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, FW'(i + 1), '0);
            cnt += int'(obsEn);
        end
        for (int i = 0; i < 6; i++) begin
            idle(1);
            cnt += int'(obsEn);
        end
        chk("exhaust_sent", cnt, 8);
        step(1, 1, 0, 32'h111, '0);
        step(1, 1, 0, 32'h222, '0);
        step(1, 1, 0, 32'h333, '0);
        chk("full_rdy_vc0", obsRdy, 0);
        step(1, 1, 1, 32'h444, '0);
        chk("vc1_rdy", obsRdy, 1);
        step(1, 1, 3, 32'h555, '0);
        chk("badvc_rdy", obsRdy, 0);
        chk("vc1_sent", obsEn, 1);
        step(1, 0, 0, '0, crdOf(0));
        chk("ret_cycle_en", obsEn, 0);
        idle(1);
        chk("ninth_en", obsEn, 1);
        chk("ninth_vc", obsVc, 0);

        // Round robin between two backlogged VCs
        doReset();
        cnt = 0;
        prevVc = -1;
        for (int i = 0; i < 10; i++) begin
            step(1, i < 8, i % 2, $urandom, '0);
            if (obsEn) begin
                if (prevVc >= 0) chk("rr_alt", obsVc, prevVc ^ 1);
                prevVc = obsVc;
                cnt++;
            end
        end
        chk("rr_count", cnt, 8);

        // Simultaneous send and return, then overflow
        doReset();
        step(1, 1, 1, 32'hABCD, '0);
        step(1, 0, 0, '0, crdOf(1));
        chk("simul_en", obsEn, 1);
        idle(1);
        chk("simul_no_ovf", obsOvf, 0);
        step(1, 0, 0, '0, crdOf(0));
        idle(1);
        chk("ovf_set", obsOvf, 1);
        idle(3);
        chk("ovf_sticky", obsOvf, 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, i < 12, 1, $urandom, '0);
            cnt += int'(obsEn);
        end
        chk("vc1_credit_kept", cnt, 8);

        // Reset with flits still queued on vc1
        doReset();
        chk("midrst_en", obsEn, 0);
        step(1, 0, 1, '0, '0);
        chk("midrst_rdy_vc1", obsRdy, 1);
        chk("midrst_ovf", obsOvf, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            cnt += int'(obsEn);
        end
        chk("no_stale", cnt, 0);

        // Random traffic: router-like credit returns first, then unconstrained
        doReset();
        for (int i = 0; i < 1200; i++) begin
            id = $urandom_range(NV - 1);
            crd = '0;
            if (i < 600) begin
                if ($urandom_range(1) == 1 && mCred[id] < CR) crd = crdOf(id);
            end else if ($urandom_range(3) == 0) begin
                crd = crdOf($urandom_range(NV));
            end
            step($urandom_range(99) != 0, $urandom_range(3) != 0, $urandom_range(NV),
                 $urandom, crd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
